// File: rtl/nus_pkg.sv
// Shared types and constants for the NUS sample packer: lane geometry,
// the lumped-word sample count, and the packer FSM state encoding.
package nus_pkg;

    localparam int SAMP_W = 9;
    localparam int NLANE  = 8;
    localparam int LUMP_W = 3 + NLANE * SAMP_W;

    typedef logic [2:0] nsamp_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH
    } pack_state_e;

    // The FIFO encodes a full word of 8 samples as a count of 0.
    function automatic logic [3:0] nsamp_to_n(input nsamp_t nsamp);
        return (nsamp == 3'd0) ? 4'd8 : {1'b0, nsamp};
    endfunction

endpackage

// File: rtl/nus_stage_buf.sv
// Staging buffer for the sample packer: pops a number of samples from the
// head and shifts the rest down, then appends new samples behind them.
module nus_stage_buf #(
    parameter int SAMP_W    = 9,
    parameter int NLANE     = 8,
    parameter int BUF_DEPTH = 16,
    parameter int FILL_W    = $clog2(BUF_DEPTH + 1)
) (
    input  logic                      clk_in,
    input  logic                      resetb,
    input  logic                      pop,
    input  logic [FILL_W-1:0]         pop_cnt,
    input  logic                      append,
    input  logic [FILL_W-1:0]         append_n,
    input  logic [NLANE*SAMP_W-1:0]   append_data,
    output logic [FILL_W-1:0]         fill,
    output logic [NLANE*SAMP_W-1:0]   head
);
    import nus_pkg::*;

    logic [SAMP_W-1:0] entries      [BUF_DEPTH];
    logic [SAMP_W-1:0] entries_next [BUF_DEPTH];
    logic [FILL_W-1:0] fill_post_pop;
    logic [FILL_W-1:0] fill_next;

    // Pop shifts survivors to index 0; appended samples land right behind them.
    always_comb begin
        fill_post_pop = pop ? (fill - pop_cnt) : fill;
        fill_next     = append ? (fill_post_pop + append_n) : fill_post_pop;
        for (int i = 0; i < BUF_DEPTH; i++) begin
            entries_next[i] = pop ? '0 : entries[i];
            for (int j = i; j < BUF_DEPTH; j++) begin
                if (pop && (j - i) == int'(pop_cnt))
                    entries_next[i] = entries[j];
            end
            for (int k = 0; k < NLANE; k++) begin
                if (append && k < int'(append_n) && i == int'(fill_post_pop) + k)
                    entries_next[i] = append_data[k*SAMP_W +: SAMP_W];
            end
        end
    end

    always_ff @(posedge clk_in or negedge resetb) begin
        if (!resetb) begin
            fill <= '0;
            for (int i = 0; i < BUF_DEPTH; i++)
                entries[i] <= '0;
        end else begin
            fill <= fill_next;
            for (int i = 0; i < BUF_DEPTH; i++)
                entries[i] <= entries_next[i];
        end
    end

    always_comb begin
        head = '0;
        for (int k = 0; k < NLANE; k++)
            head[k*SAMP_W +: SAMP_W] = entries[k];
    end

endmodule

// File: rtl/nus_sample_packer.sv
// Repacks variable-length lumped FIFO words into dense 8-sample frames.
// Optional NUSPACK_DROPCNT_EN builds the 16-bit saturating dropped-word counter.
module nus_sample_packer #(
    parameter int SAMP_W    = 9,
    parameter int NLANE     = 8,
    parameter int BUF_DEPTH = 16
) (
    input  logic                         clk_in,
    input  logic                         resetb,
    input  logic [3+NLANE*SAMP_W-1:0]    lumped_in,
    input  logic                         in_valid,
    input  logic                         en,
    input  logic                         flush_req,
    output logic [NLANE*SAMP_W-1:0]      frame_data,
    output logic [3:0]                   frame_cnt,
    output logic                         frame_valid,
    input  logic                         frame_ready,
    output logic                         flush_done,
    output logic                         ovf,
    output logic [15:0]                  drop_cnt
);
    import nus_pkg::*;

    localparam int FILL_W  = $clog2(BUF_DEPTH + 1);
    localparam int FRAME_W = NLANE * SAMP_W;
    localparam logic [FILL_W-1:0] LANES     = FILL_W'(NLANE);
    localparam logic [FILL_W:0]   DEPTH_LIM = (FILL_W + 1)'(BUF_DEPTH);

    pack_state_e          state, state_next;
    logic [FILL_W-1:0]    fill, pop_cnt, append_n, fill_post_pop;
    logic [FRAME_W-1:0]   head, head_masked;
    logic                 out_free, full_pop, part_pop, pop;
    logic                 fits, append, drop, flush_exit;

    nus_stage_buf #(
        .SAMP_W    (SAMP_W),
        .NLANE     (NLANE),
        .BUF_DEPTH (BUF_DEPTH),
        .FILL_W    (FILL_W)
    ) u_stage (
        .clk_in      (clk_in),
        .resetb      (resetb),
        .pop         (pop),
        .pop_cnt     (pop_cnt),
        .append      (append),
        .append_n    (append_n),
        .append_data (lumped_in[3 +: FRAME_W]),
        .fill        (fill),
        .head        (head)
    );

    // The overflow test uses the fill level left after this cycle's pop.
    always_comb begin
        append_n      = FILL_W'(nsamp_to_n(lumped_in[2:0]));
        out_free      = !frame_valid || frame_ready;
        full_pop      = (fill >= LANES) && out_free;
        part_pop      = (state == FLUSH) && (fill != '0) && (fill < LANES) && out_free;
        pop           = full_pop || part_pop;
        pop_cnt       = full_pop ? LANES : fill;
        fill_post_pop = pop ? (fill - pop_cnt) : fill;
        fits          = ({1'b0, fill_post_pop} + {1'b0, append_n}) <= DEPTH_LIM;
        append        = (state == RUN) && in_valid && fits;
        drop          = in_valid && (((state == RUN) && !fits) || (state == FLUSH));
        flush_exit    = (state == FLUSH) && (fill == '0) && out_free;
        head_masked   = '0;
        for (int k = 0; k < NLANE; k++) begin
            if (k < int'(pop_cnt))
                head_masked[k*SAMP_W +: SAMP_W] = head[k*SAMP_W +: SAMP_W];
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (en) state_next = RUN;
            RUN:     if (flush_req || !en) state_next = FLUSH;
            FLUSH:   if (flush_exit) state_next = en ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge resetb) begin
        if (!resetb) begin
            state       <= IDLE;
            frame_data  <= '0;
            frame_cnt   <= '0;
            frame_valid <= 1'b0;
            flush_done  <= 1'b0;
            ovf         <= 1'b0;
        end else begin
            state      <= state_next;
            flush_done <= flush_exit;
            if (drop)
                ovf <= 1'b1;
            if (pop) begin
                frame_data  <= head_masked;
                frame_cnt   <= pop_cnt[3:0];
                frame_valid <= 1'b1;
            end else if (frame_ready) begin
                frame_valid <= 1'b0;
            end
        end
    end

`ifdef NUSPACK_DROPCNT_EN
    always_ff @(posedge clk_in or negedge resetb) begin
        if (!resetb)
            drop_cnt <= '0;
        else if (drop && drop_cnt != 16'hFFFF)
            drop_cnt <= drop_cnt + 16'd1;
    end
`else
    assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_nus_sample_packer.sv
// Scoreboard bench for nus_sample_packer: a sample-queue reference model
// predicts frames and status flags; a negedge monitor compares them.
module tb_nus_sample_packer;

    localparam int NL = 8;
    localparam int SW = 9;
    localparam int DEPTH = 16;
    localparam int M_IDLE = 0, M_RUN = 1, M_FLUSH = 2;

    logic        clk_in = 1'b0;
    logic        resetb = 1'b0;
    logic [74:0] lumped_in = '0;
    logic        in_valid = 1'b0, en = 1'b0, flush_req = 1'b0, frame_ready = 1'b0;
    logic [71:0] frame_data;
    logic [3:0]  frame_cnt;
    logic        frame_valid, flush_done, ovf;
    logic [15:0] drop_cnt;

    int total = 0;
    int bad = 0;

    nus_sample_packer dut (
        .clk_in      (clk_in),
        .resetb      (resetb),
        .lumped_in   (lumped_in),
        .in_valid    (in_valid),
        .en          (en),
        .flush_req   (flush_req),
        .frame_data  (frame_data),
        .frame_cnt   (frame_cnt),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .flush_done  (flush_done),
        .ovf         (ovf),
        .drop_cnt    (drop_cnt)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [71:0] data;
        logic [3:0]  cnt;
    } frame_t;

    frame_t     exp_q[$];
    logic [8:0] samp_q[$];

    int   m_state;
    logic m_fv, m_ovf, m_fd;
    int   m_drop;
    logic cur_fv, cur_fd, cur_ovf;
    int   cur_drop;

    task automatic checkOutput(input string name, input logic [71:0] act, input logic [71:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        m_state = M_IDLE;
        samp_q.delete();
        exp_q.delete();
        m_fv = 1'b0;
        m_ovf = 1'b0;
        m_fd = 1'b0;
        m_drop = 0;
    endtask

    // Predicts what the coming clock edge does, from the inputs now applied.
    task automatic modelStep();
        int   sz;
        int   npop;
        int   n;
        bit   free;
        bit   done;
        frame_t f;
        sz   = samp_q.size();
        free = !m_fv || frame_ready;
        done = (m_state == M_FLUSH) && (sz == 0) && free;
        npop = 0;
        if (sz >= NL && free)
            npop = NL;
        else if (m_state == M_FLUSH && sz > 0 && free)
            npop = sz;
        if (npop > 0) begin
            f.data = '0;
            f.cnt  = 4'(npop);
            for (int k = 0; k < npop; k++)
                f.data[k*SW +: SW] = samp_q.pop_front();
            exp_q.push_back(f);
            m_fv = 1'b1;
        end else if (frame_ready) begin
            m_fv = 1'b0;
        end
        n = (lumped_in[2:0] == 3'd0) ? 8 : int'(lumped_in[2:0]);
        if (in_valid && m_state == M_RUN && samp_q.size() + n <= DEPTH) begin
            for (int k = 0; k < n; k++)
                samp_q.push_back(lumped_in[3 + k*SW +: SW]);
        end else if (in_valid && m_state != M_IDLE) begin
            m_ovf = 1'b1;
            if (m_drop < 65535)
                m_drop++;
        end
        m_fd = done;
        case (m_state)
            M_IDLE:  if (en) m_state = M_RUN;
            M_RUN:   if (flush_req || !en) m_state = M_FLUSH;
            default: if (done) m_state = en ? M_RUN : M_IDLE;
        endcase
    endtask

    task automatic applyStimulus(input bit v, input logic [74:0] word, input bit fr,
                                 input bit rdy, input bit e);
        @(posedge clk_in);
        cur_fv = m_fv; cur_fd = m_fd; cur_ovf = m_ovf; cur_drop = m_drop;
        #2;
        in_valid = v;
        lumped_in = word;
        flush_req = fr;
        frame_ready = rdy;
        en = e;
        modelStep();
    endtask

    task automatic doReset(input int cycles);
        @(posedge clk_in);
        #2;
        resetb = 1'b0;
        in_valid = 1'b0;
        flush_req = 1'b0;
        en = 1'b0;
        modelReset();
        cur_fv = 1'b0; cur_fd = 1'b0; cur_ovf = 1'b0; cur_drop = 0;
        #1;
        checkOutput("async_rst_valid", frame_valid, 0);
        checkOutput("async_rst_data", frame_data, 0);
        checkOutput("async_rst_cnt", frame_cnt, 0);
        checkOutput("async_rst_ovf", ovf, 0);
        checkOutput("async_rst_drop", drop_cnt, 0);
        checkOutput("async_rst_flush_done", flush_done, 0);
        repeat (cycles) @(posedge clk_in);
        cur_fv = 1'b0; cur_fd = 1'b0; cur_ovf = 1'b0; cur_drop = 0;
        #2;
        resetb = 1'b1;
        modelStep();
    endtask

    function automatic logic [74:0] mkWord(input int nsamp, input int base);
        logic [74:0] w;
        w = '0;
        w[2:0] = 3'(nsamp);
        for (int k = 0; k < NL; k++)
            w[3 + k*SW +: SW] = 9'(base + k);
        return w;
    endfunction

    function automatic logic [74:0] rndWord();
        logic [74:0] w;
        w[31:0]  = $urandom;
        w[63:32] = $urandom;
        w[74:64] = 11'($urandom_range(0, 2047));
        return w;
    endfunction

    // Monitor: compares the presented frame against the scoreboard head every
    // cycle it is valid, and retires it when the handshake completes.
    initial begin
        forever begin
            @(negedge clk_in);
            if (!resetb) begin
                checkOutput("rst_valid", frame_valid, 0);
                checkOutput("rst_data", frame_data, 0);
                checkOutput("rst_ovf", ovf, 0);
                checkOutput("rst_drop", drop_cnt, 0);
            end else begin
                checkOutput("frame_valid", frame_valid, cur_fv);
                checkOutput("flush_done", flush_done, cur_fd);
                checkOutput("ovf", ovf, cur_ovf);
`ifdef NUSPACK_DROPCNT_EN
                checkOutput("drop_cnt", drop_cnt, 72'(cur_drop));
`else
                checkOutput("drop_cnt", drop_cnt, 0);
`endif
                if (frame_valid) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("[TB] FAIL unexpected_frame: got data %0h cnt %0d expected no frame at %0t",
                                 frame_data, frame_cnt, $time);
                    end else begin
                        checkOutput("frame_data", frame_data, exp_q[0].data);
                        checkOutput("frame_cnt", frame_cnt, 72'(exp_q[0].cnt));
                        if (frame_ready)
                            void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        int vp[6] = '{90, 100, 60, 100, 30, 80};
        int rp[6] = '{100, 100, 50, 20, 70, 90};
        int fp[6] = '{0, 2, 5, 3, 8, 1};
        bit en_r;
        modelReset();
        cur_fv = 1'b0; cur_fd = 1'b0; cur_ovf = 1'b0; cur_drop = 0;
        doReset(2);

        // Single full word straight through, then nsamp 3,3,3.
        applyStimulus(0, '0, 0, 1, 1);
        applyStimulus(1, mkWord(0, 1), 0, 1, 1);
        repeat (3) applyStimulus(0, '0, 0, 1, 1);
        applyStimulus(1, mkWord(3, 16), 0, 1, 1);
        applyStimulus(1, mkWord(3, 32), 0, 1, 1);
        applyStimulus(1, mkWord(3, 48), 0, 1, 1);
        repeat (2) applyStimulus(0, '0, 0, 1, 1);
        // Top up to 5 buffered samples, then flush a partial frame.
        applyStimulus(1, mkWord(4, 64), 0, 1, 1);
        applyStimulus(0, '0, 1, 1, 1);
        repeat (5) applyStimulus(0, '0, 0, 1, 1);

        // Back-pressure with full words every cycle forces a drop.
        repeat (5) applyStimulus(1, mkWord(0, 80), 0, 0, 1);
        applyStimulus(1, mkWord(2, 100), 1, 0, 1);
        applyStimulus(1, mkWord(2, 110), 0, 0, 1);
        repeat (8) applyStimulus(0, '0, 0, 1, 1);

        // Nine samples buffered, then disable: full frame, 1-sample frame, IDLE.
        applyStimulus(1, mkWord(0, 120), 0, 0, 1);
        applyStimulus(1, mkWord(1, 140), 0, 0, 1);
        applyStimulus(0, '0, 0, 0, 0);
        repeat (6) applyStimulus(0, '0, 0, 1, 0);

        // Reset with a held frame and a partly filled buffer.
        applyStimulus(0, '0, 0, 0, 1);
        applyStimulus(1, mkWord(0, 150), 0, 0, 1);
        applyStimulus(1, mkWord(4, 170), 0, 0, 1);
        applyStimulus(1, mkWord(0, 180), 0, 0, 1);
        doReset(2);

        en_r = 1'b1;
        for (int p = 0; p < 6; p++) begin
            for (int c = 0; c < 500; c++) begin
                if (p == 3 && c == 250) begin
                    doReset(2);
                    en_r = 1'b0;
                end
                if (en_r ? ($urandom_range(99) < 2) : ($urandom_range(99) < 10))
                    en_r = !en_r;
                applyStimulus($urandom_range(99) < vp[p], rndWord(),
                              $urandom_range(99) < fp[p],
                              $urandom_range(99) < rp[p], en_r);
            end
        end

        applyStimulus(0, '0, 1, 1, 1);
        repeat (40) applyStimulus(0, '0, 0, 1, 1);
        @(negedge clk_in);
        #1;
        checkOutput("frames_left", 72'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
